// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter between the CPU and a host/loader port, with starvation guard and host lock.
// Optional statistics counters are compiled in when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          host_req,
    input  logic          host_wr,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stat_cpu_stall,
    output logic [15:0]   stat_host_gnt
);

    localparam int unsigned SW = 4;
    localparam int unsigned STW = 16;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          cpu_rd_q, cpu_rd_d;
    logic          host_rd_q, host_rd_d;
    logic          cpu_gnt;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state_q <= ARB;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (host_gnt && host_lock) state_d = LOCK;
            LOCK:    if (!host_lock)            state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Grant selection: lock hold, then starvation override, then CPU priority
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (state_q == LOCK && host_lock) begin
            host_gnt = host_req;
        end else if (host_req && starve_q >= LIMIT) begin
            host_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (host_req) begin
            host_gnt = 1'b1;
        end
    end

    // RAM port mux; idle cycles park the address on the CPU side
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wr    = 1'b0;
        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wr    = host_wr;
        end else if (cpu_gnt) begin
            mem_wr = cpu_wr;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        starve_d = '0;
        if (host_req && !host_gnt)
            starve_d = (starve_q == '1) ? starve_q : starve_q + SW'(1);
        cpu_rd_d  = cpu_gnt & ~cpu_wr;
        host_rd_d = host_gnt & ~host_wr;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            starve_q  <= '0;
            cpu_rd_q  <= 1'b0;
            host_rd_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            cpu_rd_q  <= cpu_rd_d;
            host_rd_q <= host_rd_d;
        end
    end

    // A reset arriving while a read is in flight kills its return pulse
    assign cpu_rvalid  = cpu_rd_q & ~Reset;
    assign host_rvalid = host_rd_q & ~Reset;
    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [STW-1:0] stat_stall_q, stat_gnt_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stat_stall_q <= '0;
            stat_gnt_q   <= '0;
        end else begin
            if (cpu_stall && stat_stall_q != '1) stat_stall_q <= stat_stall_q + STW'(1);
            if (host_gnt && stat_gnt_q != '1)    stat_gnt_q   <= stat_gnt_q + STW'(1);
        end
    end

    assign stat_cpu_stall = stat_stall_q;
    assign stat_host_gnt  = stat_gnt_q;
`else
    assign stat_cpu_stall = STW'(0);
    assign stat_host_gnt  = STW'(0);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected read data is queued at grant time and matched on rvalid.
module tb_dmem_arbiter;

    logic        Clock;
    logic        Reset;
    logic        cpu_req, cpu_wr;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_stall;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        host_req, host_wr, host_lock;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    logic [7:0]  mem_addr;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] stat_cpu_stall, stat_host_gnt;

    dmem_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_wr(host_wr), .host_lock(host_lock),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_cpu_stall(stat_cpu_stall), .stat_host_gnt(stat_host_gnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous RAM with one-cycle read latency
    logic [15:0] ram [256];
    always @(posedge Clock) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        q_cpu[$];
    exp_t        q_host[$];
    logic [15:0] shadow [256];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read-return monitor: every cycle rvalid must match the scoreboard head
    always @(negedge Clock) begin
        automatic bit ec = (q_cpu.size() != 0) && (q_cpu[0].due == cyc);
        automatic bit eh = (q_host.size() != 0) && (q_host[0].due == cyc);
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(ec));
        check("host_rvalid", 32'(host_rvalid), 32'(eh));
        if (ec) begin
            check("cpu_rdata", 32'(cpu_rdata), 32'(q_cpu[0].data));
            void'(q_cpu.pop_front());
        end
        if (eh) begin
            check("host_rdata", 32'(host_rdata), 32'(q_host[0].data));
            void'(q_host.pop_front());
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                         input logic hr, input logic hw, input logic hl, input logic [7:0] ha,
                         input logic [15:0] hd);
        cpu_req = cr;  cpu_wr = cw;  cpu_addr = ca;  cpu_wdata = cd;
        host_req = hr; host_wr = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // win: 0 none, 1 CPU, 2 host; checks grant/mux and books the expected effect
    task automatic expect_cycle(input int win, input string tag);
        logic [7:0] ea;
        logic       ew;
        logic [15:0] ed;
        #1;
        ea = cpu_addr; ew = 1'b0; ed = cpu_wdata;
        if (win == 1) begin ew = cpu_wr; end
        if (win == 2) begin ea = host_addr; ew = host_wr; ed = host_wdata; end
        check({tag, "_hgnt"}, 32'(host_gnt), 32'(win == 2));
        check({tag, "_stall"}, 32'(cpu_stall), 32'(cpu_req && win != 1));
        check({tag, "_maddr"}, 32'(mem_addr), 32'(ea));
        check({tag, "_mwr"}, 32'(mem_wr), 32'(ew));
        if (ew) begin
            check({tag, "_mwdata"}, 32'(mem_wdata), 32'(ed));
            shadow[ea] = ed;
        end else if (win == 1) begin
            q_cpu.push_back('{due: cyc + 1, data: shadow[ea]});
        end else if (win == 2) begin
            q_host.push_back('{due: cyc + 1, data: shadow[ea]});
        end
    endtask

    initial begin
        Reset = 1'b1;
        drive(1, 1, 8'h10, 16'h1234, 1, 0, 0, 8'h20, 16'h0);
        tick();
        tick();
        Reset = 1'b0;
        expect_cycle(1, "post_rst");
        tick();

        drive(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        expect_cycle(1, "cpu_rd");
        tick();
        drive(0, 0, 8'h33, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        expect_cycle(0, "idle");
        tick();
        drive(0, 0, 8'h33, 16'h0, 1, 1, 0, 8'h20, 16'hBEEF);
        expect_cycle(2, "host_wr");
        tick();

        // Fresh reset so the statistics window covers only the starvation run
        Reset = 1'b1;
        drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 8'h10, 16'h0, 1, 0, 0, 8'h20, 16'h0);
            expect_cycle((i % 5 == 4) ? 2 : 1, "starve");
            tick();
        end
        drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        expect_cycle(0, "post_starve");
`ifdef DMEM_ARB_STATS_EN
        check("stat_cpu_stall", 32'(stat_cpu_stall), 32'd2);
        check("stat_host_gnt", 32'(stat_host_gnt), 32'd2);
`else
        check("stat_cpu_stall", 32'(stat_cpu_stall), 32'd0);
        check("stat_host_gnt", 32'(stat_host_gnt), 32'd0);
`endif
        tick();

        // Locked host burst with a mid-burst no-request hold cycle
        drive(0, 0, 8'h10, 16'h0, 1, 1, 1, 8'hA0, 16'h5A00);
        expect_cycle(2, "lock_a0");
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(1, 0, 8'h10, 16'h0, 1, 1, 1, 8'(8'hA0 + i), 16'(16'h5A00 + i));
            expect_cycle(2, "lock_burst");
            tick();
        end
        drive(1, 0, 8'h10, 16'h0, 0, 0, 1, 8'h00, 16'h0);
        expect_cycle(0, "lock_hold");
        tick();
        drive(1, 0, 8'h10, 16'h0, 1, 1, 1, 8'hA3, 16'h5A03);
        expect_cycle(2, "lock_a3");
        tick();
        drive(1, 0, 8'h10, 16'h0, 1, 0, 0, 8'hA2, 16'h0);
        expect_cycle(1, "lock_release");
        tick();
        drive(0, 0, 8'h10, 16'h0, 1, 0, 0, 8'hA2, 16'h0);
        expect_cycle(2, "host_rd_a2");
        tick();
        drive(1, 0, 8'hA3, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        expect_cycle(1, "cpu_rd_a3");
        tick();

        // Reset right after a granted locked host read: pulse dropped, state back to ARB
        drive(0, 0, 8'h00, 16'h0, 1, 0, 1, 8'h20, 16'h0);
        expect_cycle(2, "rst_pend_rd");
        void'(q_host.pop_back());
        tick();
        Reset = 1'b1;
        drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        tick();
        Reset = 1'b0;
        drive(1, 0, 8'h20, 16'h0, 1, 0, 1, 8'hA0, 16'h0);
        expect_cycle(1, "post_rst_arb");
        tick();
        drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        expect_cycle(0, "final_idle");
        tick();
        tick();

        check("cpu_q_empty", 32'(q_cpu.size()), 32'd0);
        check("host_q_empty", 32'(q_host.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
